kgp_trace_buffer: RTL and testbench
===================================

KGP_TRACE_BUFFER -- requirements
Module: kgp_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace entries stored; power of two, 2..256.
REQ-002 SHALL have parameter DATA_W, default 32, width of PC and writeback data.
REQ-003 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port arm  input  1  one-cycle pulse that starts a capture session.
REQ-007 SHALL have port trig_en  input  1  1 = wait for PC match; 0 = trigger on the first commit.
REQ-008 SHALL have port trig_pc  input  DATA_W  trigger PC value.
REQ-009 SHALL have port stop_on_full  input  1  1 = stop when full; 0 = ring mode, overwrite the oldest entry.
REQ-010 SHALL have port commit_valid  input  1  an instruction retires this cycle.
REQ-011 SHALL have ports commit_pc (DATA_W), wb_en (1), wb_addr (RADDR_W), wb_data (DATA_W) and mem_wr (1), all inputs, giving retiring-instruction info.
REQ-012 SHALL have port rd_en  input  1  pop request.
REQ-013 SHALL have ports rd_pc, rd_wb_en, rd_wb_addr, rd_wb_data and rd_mem_wr, all outputs, giving the popped entry fields.
REQ-014 SHALL have port rd_valid  output  1  popped entry is valid this cycle.
REQ-015 SHALL have port count  output  clog2(DEPTH+1)  number of stored entries.
REQ-016 SHALL have ports empty, full, triggered, overflow and done, each an output of width 1, giving status flags.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE and DONE.
REQ-018 SHALL move from IDLE to ARMED on arm, clear storage (count=0) and clear overflow.
REQ-019 SHALL move from ARMED to CAPTURE on commit_valid and (!trig_en or commit_pc==trig_pc); the triggering commit SHALL be stored; triggered SHALL be set on the next edge.
REQ-020 SHALL, in CAPTURE, push one entry per cycle with commit_valid; commits without commit_valid SHALL be ignored.
REQ-021 SHALL, in CAPTURE with stop_on_full=1, move to DONE on the edge where count becomes DEPTH; DONE SHALL accept no pushes.
REQ-022 SHALL, in CAPTURE with stop_on_full=0, overwrite the oldest entry when pushing while full, keep count=DEPTH and set sticky overflow.
REQ-023 SHALL treat arm in any state other than IDLE as a restart: storage cleared, triggered/overflow/done cleared, state ARMED.
REQ-024 SHALL pop the oldest entry on rd_en with !empty, in any state; rd_* and rd_valid SHALL be registered and appear one cycle after rd_en.
REQ-025 SHALL ignore rd_en with empty; rd_valid SHALL be 0 the next cycle and rd_* SHALL hold their previous values.
REQ-026 SHALL, on a simultaneous push and pop, leave count unchanged, return the oldest entry and not set overflow, including when full in ring mode.
REQ-027 SHALL, on a simultaneous push and pop in DONE, perform the pop only.
REQ-028 SHALL wrap read and write pointers modulo DEPTH with no gap entries.
REQ-029 SHALL drive empty=(count==0), full=(count==DEPTH) and done=(state==DONE) combinationally from registers.
REQ-030 SHALL give arm priority over push/pop in the same cycle; the commit SHALL then be evaluated as the ARMED trigger condition on the following cycle only.

Reset
REQ-031 SHALL, on rst, set state IDLE, both pointers 0, count 0, rd_valid 0, rd_* 0, triggered 0, overflow 0, and done 0; storage contents need not be cleared.
REQ-032 SHALL give rst priority over arm, push and pop; rst mid-capture SHALL discard all entries.

Verification
REQ-033 SHALL verify: DEPTH=4, trig_en=0, stop_on_full=1, arm, 6 commits PC 0,4,...,20 -> count=4, done=1, pops return PC 0,4,8,12, then empty=1.
REQ-034 SHALL verify: trig_en=1, trig_pc=0x10, commits PC 0x0..0x1C step 4 -> triggered rises after PC 0x10; first pop gives PC 0x10 and wb fields match.
REQ-035 SHALL verify: DEPTH=4, ring mode, 7 commits PC 1..7 -> count=4, overflow=1, pops give 4,5,6,7.
REQ-036 SHALL verify: full in ring mode, commit PC 9 with rd_en in the same cycle -> rd_pc=oldest next cycle, count stays 4, overflow unchanged.
REQ-037 SHALL verify: rst asserted after 2 captured entries -> next cycle count=0, empty=1, state IDLE; a commit without arm is not stored.
REQ-038 SHALL verify: rd_en on empty -> rd_valid=0, count stays 0, no pointer movement.

Source files
------------

// File: rtl/kgp_trace_buffer.sv
// Retired-instruction trace buffer: arm, trigger on PC, capture, pop.
// Ports: arm/trig_*/stop_on_full control, commit_* in, rd_* pop out, status.
module kgp_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic                       stop_on_full,
  input  logic                       commit_valid,
  input  logic [DATA_W-1:0]          commit_pc,
  input  logic                       wb_en,
  input  logic [RADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       mem_wr,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_pc,
  output logic                       rd_wb_en,
  output logic [RADDR_W-1:0]         rd_wb_addr,
  output logic [DATA_W-1:0]          rd_wb_data,
  output logic                       rd_mem_wr,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       triggered,
  output logic                       overflow,
  output logic                       done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic               wb_en;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               mem_wr;
  } entry_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               trig_q, trig_d;
  logic               ovf_q, ovf_d;
  logic               rd_valid_q, rd_valid_d;
  entry_t             rd_ent_q, rd_ent_d;
  entry_t             mem_q [DEPTH];

  logic   hit;
  logic   push;
  logic   pop;
  logic   full_q;
  entry_t wr_ent;

  assign full_q = (count_q == CNT_W'(DEPTH));
  assign hit    = commit_valid &&
                  (!trig_en || commit_pc == trig_pc);

  assign wr_ent = '{pc:      commit_pc,
                    wb_en:   wb_en,
                    wb_addr: wb_addr,
                    wb_data: wb_data,
                    mem_wr:  mem_wr};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    trig_d     = trig_q;
    ovf_d      = ovf_q;
    rd_valid_d = 1'b0;
    rd_ent_d   = rd_ent_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (arm) begin
      // arm wins over any push/pop this cycle
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      trig_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      pop = rd_en && (count_q != '0);

      case (state_q)
        S_ARMED: begin
          if (hit) begin
            push    = 1'b1;
            state_d = S_CAPTURE;
            trig_d  = 1'b1;
          end
        end
        S_CAPTURE: push = commit_valid;
        default:   push = 1'b0;
      endcase

      // in stop mode a full buffer only takes a push that frees a slot
      if (push && full_q && stop_on_full && !pop)
        push = 1'b0;

      if (pop) begin
        rd_valid_d = 1'b1;
        rd_ent_d   = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end

      if (push)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);

      if (push && !pop) begin
        if (full_q) begin
          // ring overwrite: the oldest entry is dropped
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          ovf_d    = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end

      if (state_q == S_CAPTURE && stop_on_full &&
          count_d == CNT_W'(DEPTH))
        state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      trig_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ent_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      trig_q     <= trig_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_ent_q   <= rd_ent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem_q[wr_ptr_q] <= wr_ent;
  end

  assign rd_pc      = rd_ent_q.pc;
  assign rd_wb_en   = rd_ent_q.wb_en;
  assign rd_wb_addr = rd_ent_q.wb_addr;
  assign rd_wb_data = rd_ent_q.wb_data;
  assign rd_mem_wr  = rd_ent_q.mem_wr;
  assign rd_valid   = rd_valid_q;
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = full_q;
  assign triggered  = trig_q;
  assign overflow   = ovf_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_kgp_trace_buffer.sv
// Bench for kgp_trace_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the capture rules.
module tb_kgp_trace_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          mem_wr;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, arm, trig_en, stop_on_full;
  logic [DW-1:0] trig_pc;
  logic          commit_valid, wb_en, mem_wr, rd_en;
  logic [DW-1:0] commit_pc, wb_data;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] rd_pc, rd_wb_data;
  logic          rd_wb_en, rd_mem_wr, rd_valid;
  logic [AW-1:0] rd_wb_addr;
  logic [2:0]    count;
  logic          empty, full, triggered, overflow, done;

  int n_tests = 0;
  int n_fail  = 0;

  // model
  ent_t q[$];
  bit   m_armed, m_cap, m_done, m_trig, m_ovf, m_rv;
  ent_t m_rd;

  always #5 clk = ~clk;

  kgp_trace_buffer #(
    .DEPTH(DEPTH), .DATA_W(DW), .RADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm),
    .trig_en(trig_en), .trig_pc(trig_pc),
    .stop_on_full(stop_on_full),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .mem_wr(mem_wr),
    .rd_en(rd_en),
    .rd_pc(rd_pc), .rd_wb_en(rd_wb_en),
    .rd_wb_addr(rd_wb_addr), .rd_wb_data(rd_wb_data),
    .rd_mem_wr(rd_mem_wr), .rd_valid(rd_valid),
    .count(count), .empty(empty), .full(full),
    .triggered(triggered), .overflow(overflow),
    .done(done)
  );

  task automatic chk(input string tag, input string what,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h",
             tag, what, obs, exp);
    end
  endtask

  task automatic model_step();
    bit   hit, psh, pp;
    ent_t e;
    e = '{pc: commit_pc, wb_en: wb_en, wb_addr: wb_addr,
          wb_data: wb_data, mem_wr: mem_wr};
    if (rst) begin
      q.delete();
      m_armed = 0; m_cap = 0; m_done = 0;
      m_trig = 0; m_ovf = 0; m_rv = 0; m_rd = '0;
    end else if (arm) begin
      q.delete();
      m_armed = 1; m_cap = 0; m_done = 0;
      m_trig = 0; m_ovf = 0; m_rv = 0;
    end else begin
      pp = rd_en && q.size() > 0;
      m_rv = pp;
      if (pp) m_rd = q.pop_front();
      hit = commit_valid &&
            (!trig_en || commit_pc == trig_pc);
      psh = (m_armed && hit) || (m_cap && commit_valid);
      if (m_armed && hit) begin
        m_armed = 0; m_cap = 1; m_trig = 1;
      end
      if (psh) begin
        if (q.size() == DEPTH) begin
          if (stop_on_full) psh = 0;
          else begin
            void'(q.pop_front());
            m_ovf = 1;
          end
        end
        if (psh) q.push_back(e);
      end
      if (m_cap && stop_on_full && q.size() == DEPTH) begin
        m_cap = 0; m_done = 1;
      end
    end
  endtask

  task automatic check(input string tag);
    chk(tag, "count", 64'(count), 64'(q.size()));
    chk(tag, "empty", 64'(empty), 64'(q.size() == 0));
    chk(tag, "full", 64'(full), 64'(q.size() == DEPTH));
    chk(tag, "done", 64'(done), 64'(m_done));
    chk(tag, "trig", 64'(triggered), 64'(m_trig));
    chk(tag, "ovf", 64'(overflow), 64'(m_ovf));
    chk(tag, "rd_valid", 64'(rd_valid), 64'(m_rv));
    chk(tag, "rd_pc", 64'(rd_pc), 64'(m_rd.pc));
    chk(tag, "rd_data", 64'(rd_wb_data), 64'(m_rd.wb_data));
    chk(tag, "rd_misc",
        64'({rd_wb_en, rd_wb_addr, rd_mem_wr}),
        64'({m_rd.wb_en, m_rd.wb_addr, m_rd.mem_wr}));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic quiet();
    rst = 0; arm = 0; rd_en = 0; commit_valid = 0;
  endtask

  task automatic cmt(input logic v, input logic [DW-1:0] pc);
    commit_valid = v;
    commit_pc    = pc;
    wb_en        = 1'($urandom);
    wb_addr      = AW'($urandom);
    wb_data      = $urandom;
    mem_wr       = 1'($urandom);
  endtask

  initial begin
    rst = 1; arm = 0; trig_en = 0; trig_pc = '0;
    stop_on_full = 1; rd_en = 0;
    cmt(0, '0);
    step("reset");
    step("reset2");
    quiet();

    // stop-on-full capture, trigger on first commit
    stop_on_full = 1; trig_en = 0;
    arm = 1; step("arm_stop"); arm = 0;
    for (int i = 0; i < 6; i++) begin
      cmt(1, DW'(i * 4));
      step("stop_cap");
    end
    cmt(0, '0);
    chk("stop", "count4", 64'(count), 64'd4);
    chk("stop", "done1", 64'(done), 64'd1);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1;
      step("stop_pop");
      chk("stop", "pop_pc", 64'(rd_pc), 64'(i * 4));
    end
    chk("stop", "empty", 64'(empty), 64'd1);
    step("empty_pop");
    chk("empty_pop", "rdv0", 64'(rd_valid), 64'd0);
    chk("empty_pop", "hold", 64'(rd_pc), 64'd12);
    rd_en = 0;

    // PC-match trigger
    stop_on_full = 0; trig_en = 1; trig_pc = 32'h10;
    arm = 1; step("arm_pc"); arm = 0;
    for (int i = 0; i < 8; i++) begin
      cmt(1, DW'(i * 4));
      step("pc_cap");
      chk("pc_cap", "trig", 64'(triggered),
          64'(i * 4 >= 16));
    end
    cmt(0, '0);
    rd_en = 1; step("pc_pop"); rd_en = 0;
    chk("pc_pop", "pc10", 64'(rd_pc), 64'h10);

    // ring mode overflow, then push+pop while full
    trig_en = 0;
    arm = 1; step("arm_ring"); arm = 0;
    for (int i = 1; i <= 7; i++) begin
      cmt(1, DW'(i));
      step("ring_cap");
    end
    chk("ring", "ovf", 64'(overflow), 64'd1);
    chk("ring", "count", 64'(count), 64'd4);
    cmt(1, 32'd9); rd_en = 1;
    step("ring_pp");
    chk("ring_pp", "oldest", 64'(rd_pc), 64'd4);
    chk("ring_pp", "count", 64'(count), 64'd4);
    cmt(0, '0);
    for (int i = 0; i < 4; i++) step("ring_pop");
    chk("ring", "last", 64'(rd_pc), 64'd9);
    rd_en = 0;

    // reset mid-capture, then commits without arm
    arm = 1; step("arm_rst"); arm = 0;
    cmt(1, 32'd100); step("rst_cap");
    cmt(1, 32'd104); step("rst_cap");
    cmt(0, '0);
    rst = 1; step("rst_mid"); rst = 0;
    chk("rst_mid", "count0", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cmt(1, DW'(i));
      step("no_arm");
    end
    chk("no_arm", "empty", 64'(empty), 64'd1);

    // arm beats a same-cycle commit
    trig_en = 0; stop_on_full = 1;
    arm = 1; cmt(1, 32'd50); step("arm_pri"); arm = 0;
    chk("arm_pri", "count0", 64'(count), 64'd0);
    cmt(1, 32'd54); step("arm_next");
    cmt(0, '0);
    rd_en = 1; step("arm_pop"); rd_en = 0;
    chk("arm_pop", "pc", 64'(rd_pc), 64'd54);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      arm = ($urandom_range(0, 29) == 0);
      if (arm) begin
        stop_on_full = 1'($urandom);
        trig_en      = 1'($urandom);
        trig_pc      = DW'($urandom_range(0, 3) * 4);
      end
      cmt($urandom_range(0, 2) != 0,
          DW'($urandom_range(0, 3) * 4));
      rd_en = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
